grf_wr_arb: RTL and testbench

- Arbitrates the single GRF write port (regwrite/wa/wd) between two writers.
  - Requester 0 (WB): the normal instruction writeback path. It has priority.
  - Requester 1 (LU): the long-latency unit result path (mult/div, late load). It is buffered in a small FIFO.
- Sits between the writeback sources and grf.
- Publishes a pending-destination mask so the hazard unit can stall readers of registers that still have a queued write.

---
 rtl/grf_wr_arb.sv | 193 +++++++++++++++++++
 tb/tb_grf_wr_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : grf_wr_arb
//  Description : Arbiter for the single GRF write port. The writeback path
//                (WB) has priority. Long-latency unit results (LU) are queued
//                in a small circular FIFO. A starvation counter forces the
//                FIFO head through after MAX_WAIT bypassed cycles. A
//                pending-destination mask lets the hazard unit stall readers
//                of registers that still have a queued write.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_wr_arb #(
    parameter int DEPTH    = 2,   // LU FIFO entries, power of two, >= 2
    parameter int MAX_WAIT = 3    // bypass cycles tolerated for the FIFO head, >= 1
) (
    input  logic                     clk,
    input  logic                     rst,          // asynchronous, active low

    // Writeback requester (priority)
    input  logic                     wb_valid,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    output logic                     wb_ready,

    // Long-latency unit requester (queued)
    input  logic                     lu_valid,
    input  logic [4:0]               lu_addr,
    input  logic [31:0]              lu_data,
    output logic                     lu_ready,

    // GRF write port
    output logic                     grf_we,
    output logic [4:0]               grf_wa,
    output logic [31:0]              grf_wd,

    // Hazard-unit visibility
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_AW = $clog2(DEPTH);        // pointer width
    localparam int c_WW = $clog2(MAX_WAIT + 1); // starvation counter width

    localparam logic [c_AW:0]   c_DEPTH    = DEPTH[c_AW:0];
    localparam logic [c_WW-1:0] c_MAX_WAIT = MAX_WAIT[c_WW-1:0];

    // ------------------------------------------------------------------------
    // FIFO storage and control state
    // ------------------------------------------------------------------------
    logic [4:0]        r_ent_addr [DEPTH];
    logic [31:0]       r_ent_data [DEPTH];
    logic [DEPTH-1:0]  r_ent_vld;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_cnt;
    logic [c_WW-1:0]   r_wait;

    // Output register
    logic              r_grf_we;
    logic [4:0]        r_grf_wa;
    logic [31:0]       r_grf_wd;

    // ------------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------------
    logic              w_fifo_nonempty;
    logic              w_starve;
    logic              w_sel_fifo;
    logic              w_sel_wb;
    logic              w_pop;
    logic              w_push;
    logic              w_lu_ready;
    logic [4:0]        w_head_addr;
    logic [31:0]       w_head_data;
    logic [31:0]       w_mask;

    assign w_fifo_nonempty = (r_cnt != '0);

    // Starvation is judged purely from registered state, so it is glitch-free
    // with respect to the requester inputs.
    assign w_starve   = w_fifo_nonempty && (r_wait == c_MAX_WAIT);

    // FIFO head wins when starved, or when WB has nothing to write.
    assign w_sel_fifo = w_fifo_nonempty && (w_starve || !wb_valid);
    assign w_sel_wb   = !w_starve && wb_valid;

    // Full is judged on occupancy before this cycle's pop: no push into a
    // full FIFO even if the head leaves in the same cycle.
    assign w_lu_ready = (r_cnt < c_DEPTH);

    assign w_pop      = w_sel_fifo;
    // Writes to $0 are accepted but never queued.
    assign w_push     = lu_valid && w_lu_ready && (lu_addr != 5'd0);

    assign w_head_addr = r_ent_addr[r_rd_ptr];
    assign w_head_data = r_ent_data[r_rd_ptr];

    // Pending mask: one-hot of every occupied entry's destination, $0 excluded.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ent_vld[i]) begin
                w_mask[r_ent_addr[i]] = 1'b1;
            end
        end
        w_mask[0] = 1'b0;
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // FIFO payload storage; contents are qualified by r_ent_vld so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_addr[r_wr_ptr] <= lu_addr;
            r_ent_data[r_wr_ptr] <= lu_data;
        end
    end

    // FIFO pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_ent_vld <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr            <= r_rd_ptr + 1'b1;
                r_ent_vld[r_rd_ptr] <= 1'b0;
            end
            // Push and pop never share a slot: pop needs non-empty, push
            // needs not-full, so equal pointers imply only one can happen.
            if (w_push) begin
                r_wr_ptr            <= r_wr_ptr + 1'b1;
                r_ent_vld[r_wr_ptr] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Starvation counter: counts cycles the non-empty head is bypassed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (w_pop || !w_fifo_nonempty) begin
            r_wait <= '0;
        end else if (r_wait != c_MAX_WAIT) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // GRF write register; address/data hold when no write is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grf_we <= 1'b0;
            r_grf_wa <= '0;
            r_grf_wd <= '0;
        end else if (w_sel_fifo) begin
            // Queued entries are never $0, so a FIFO selection always writes.
            r_grf_we <= 1'b1;
            r_grf_wa <= w_head_addr;
            r_grf_wd <= w_head_data;
        end else if (w_sel_wb && (wb_addr != 5'd0)) begin
            r_grf_we <= 1'b1;
            r_grf_wa <= wb_addr;
            r_grf_wd <= wb_data;
        end else begin
            r_grf_we <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wb_ready     = !w_starve;
    assign lu_ready     = w_lu_ready;
    assign grf_we       = r_grf_we;
    assign grf_wa       = r_grf_wa;
    assign grf_wd       = r_grf_wd;
    assign pending_mask = w_mask;
    assign fifo_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_grf_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_wr_arb
//  Description : Randomized self-checking bench for grf_wr_arb against a
//                queue-based reference model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_wr_arb;

    localparam int c_DEPTH    = 2;
    localparam int c_MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd;
    logic [31:0] pending_mask;
    logic [1:0]  fifo_cnt;

    grf_wr_arb #(
        .DEPTH    (c_DEPTH),
        .MAX_WAIT (c_MAX_WAIT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .lu_valid     (lu_valid),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .grf_we       (grf_we),
        .grf_wa       (grf_wa),
        .grf_wd       (grf_wd),
        .pending_mask (pending_mask),
        .fifo_cnt     (fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: an ordered queue of pending LU writes plus a count of
    // how many consecutive cycles the oldest one has been passed over.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_wait;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_wbr;
    logic        m_lur;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m = m | (32'd1 << mq[i].a);
        return m & ~32'd1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wait = 0;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        m_wbr  = 1'b1;
        m_lur  = 1'b1;
    endtask

    // Check readies for the currently driven inputs, then advance the model
    // by one clock edge.
    task automatic model_step();
        int   sz;
        logic starve;
        ent_t e;
        sz     = mq.size();
        starve = (sz != 0) && (m_wait == c_MAX_WAIT);
        m_wbr  = !starve;
        m_lur  = (sz < c_DEPTH);
        check("wb_ready", {31'd0, wb_ready}, {31'd0, m_wbr});
        check("lu_ready", {31'd0, lu_ready}, {31'd0, m_lur});
        if (sz != 0 && (starve || !wb_valid)) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_wa   = e.a;
            m_wd   = e.d;
            m_wait = 0;
        end else begin
            if (wb_valid && wb_addr != 5'd0) begin
                m_we = 1'b1;
                m_wa = wb_addr;
                m_wd = wb_data;
            end else begin
                m_we = 1'b0;
            end
            if (sz == 0)                 m_wait = 0;
            else if (m_wait < c_MAX_WAIT) m_wait++;
        end
        if (lu_valid && m_lur && lu_addr != 5'd0) begin
            e.a = lu_addr;
            e.d = lu_data;
            mq.push_back(e);
        end
    endtask

    // Compare all registered outputs with the model.
    task automatic check_outputs();
        check("grf_we",       {31'd0, grf_we},   {31'd0, m_we});
        check("grf_wa",       {27'd0, grf_wa},   {27'd0, m_wa});
        check("grf_wd",       grf_wd,            m_wd);
        check("fifo_cnt",     {30'd0, fifo_cnt}, mq.size());
        check("pending_mask", pending_mask,      model_mask());
    endtask

    function automatic logic [4:0] rand_addr(input int p_zero);
        if ($urandom_range(99) < p_zero) return 5'd0;
        return 5'($urandom_range(31, 1));
    endfunction

    // One cycle: check last edge's results, drive new requests (holding any
    // not-yet-accepted ones), check readies and step the model.
    task automatic run_cycle(input int p_wb, input int p_lu, input int p_zero);
        @(negedge clk);
        check_outputs();
        if (!(wb_valid && !m_wbr)) begin
            wb_valid = ($urandom_range(99) < p_wb);
            wb_addr  = rand_addr(p_zero);
            wb_data  = $urandom;
        end
        if (!(lu_valid && !m_lur)) begin
            lu_valid = ($urandom_range(99) < p_lu);
            lu_addr  = rand_addr(p_zero);
            lu_data  = $urandom;
        end
        #1;
        model_step();
    endtask

    // Asynchronous reset asserted between edges while the FIFO is busy.
    task automatic reset_midstream();
        repeat (4) run_cycle(100, 100, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_grf_we",   {31'd0, grf_we},   32'd0);
        check("rst_grf_wa",   {27'd0, grf_wa},   32'd0);
        check("rst_grf_wd",   grf_wd,            32'd0);
        check("rst_mask",     pending_mask,      32'd0);
        check("rst_fifo_cnt", {30'd0, fifo_cnt}, 32'd0);
        wb_valid = 1'b0;
        lu_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_step();
    endtask

    int ph_wb   [6] = '{100, 30, 90, 60, 20, 80};
    int ph_lu   [6] = '{40, 20, 90, 60, 90, 50};
    int ph_zero [6] = '{5, 10, 0, 30, 20, 10};

    initial begin
        rst      = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        lu_valid = 1'b0;
        lu_addr  = '0;
        lu_data  = '0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        #1;
        model_step();

        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 400; c++) begin
                run_cycle(ph_wb[p], ph_lu[p], ph_zero[p]);
            end
            reset_midstream();
        end

        // Drain with no new requests, then confirm quiescence.
        wb_valid = 1'b0;
        lu_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_outputs();
            #1;
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
